uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop framing with a
// one-word output register, valid/ready handoff and sticky-per-word error flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_tick,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;     // parity error of the frame in flight
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 load;             // stop bit sampled: publish the word

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  // Framing FSM: mid-bit sampling via the 16x tick counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (RX_tick) begin
          if (cnt_q == 4'd7) begin
            // Line back high at mid-start means a glitch: drop it silently.
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (RX_tick) begin
          cnt_d = cnt_q + 4'd1;   // 15 wraps to 0 at the sample tick
          if (cnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      PARITY: begin
        if (RX_tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // XOR of data+parity is 0 for good even parity, 1 for good odd.
            par_d   = (^shift_q) ^ rx_s_q ^ PARITY_ODD;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (RX_tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a load always wins; a handshake alone clears valid.
  always_comb begin
    data_d  = data_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (load) begin
      data_d  = shift_q;
      fe_d    = ~rx_s_q;
      pe_d    = PARITY_EN ? par_q : 1'b0;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ready;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
